alu_uart_sequencer: RTL and testbench
=====================================

Name: alu_uart_sequencer

Overview:
Bridges the byte-stream UART pair and the combinational ALU. It collects operand A, operand B and the operation code as three received bytes, drives them onto the ALU inputs, registers the ALU result and hands it to the UART transmitter through a start/done handshake. The block sits between uart_rx/uart_tx and the ALU in the board top level.

Parameters:
NBITS, 8, width of operands, result and UART data byte
COD_OP, 6, width of operation code; must be <= NBITS; taken from the low COD_OP bits of the third byte

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
rx_data  in  NBITS  byte from UART receiver, valid when rx_done=1
rx_done  in  1  one-cycle strobe: rx_data holds a new byte
operando_A  out  NBITS  registered operand A to ALU
operando_B  out  NBITS  registered operand B to ALU
cod_operacion  out  COD_OP  registered opcode to ALU
alu_result  in  NBITS  combinational result from ALU
tx_data  out  NBITS  result byte to UART transmitter
tx_start  out  1  one-cycle pulse: start transmitting tx_data
tx_done  in  1  one-cycle strobe from transmitter: byte sent
busy  out  1  high in EXEC, SEND, WAIT_TX

Behaviour:
- Reset (asynchronous, active-high, any state): state=GET_A; operando_A, operando_B, tx_data = 0; cod_operacion = 0; tx_start = 0; busy = 0.
- FSM states: GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX. Transitions on the rising clk edge.
- GET_A: rx_done=1 -> operando_A<=rx_data; go GET_B.
- GET_B: rx_done=1 -> operando_B<=rx_data; go GET_OP.
- GET_OP: rx_done=1 -> cod_operacion<=rx_data[COD_OP-1:0]; go EXEC. Upper bits are discarded.
- EXEC: one cycle. tx_data<=alu_result, sampled with the new opcode already stable. Go SEND.
- SEND: tx_start=1 for exactly this cycle. Go WAIT_TX.
- WAIT_TX: hold tx_data; wait for tx_done=1, then go GET_A. tx_done seen in any other state is ignored.
- Latency: from the rx_done of the opcode byte, tx_data is valid 2 edges later and tx_start is high in the 3rd cycle.
- rx_done while busy=1 (EXEC, SEND, WAIT_TX): the byte is dropped and no register changes.
- Operand registers hold their values until overwritten; operando_A and operando_B stay stable through WAIT_TX.
- tx_start is registered/decoded from state only, so it is glitch-free. It is never high two consecutive cycles.
- Invalid opcode: no special handling; the ALU default result (all ones) is transmitted.
- Reset asserted mid-transaction aborts it and drops any pending transmission. tx_start is forced low immediately.

Optional Feature:
ALU_SEQ_OVERRUN_EN. When defined, an extra output port overrun (1 bit) is added. It is set sticky when rx_done=1 while busy=1, and cleared only by reset. When not defined, the port does not exist and dropped bytes are silent.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode constants (ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111);
  - the state encoding as a typedef enum (3 bits);
  - default NBITS/COD_OP.
- No sub-module is needed: one FSM plus datapath registers. The ALU stays an external instance at top level.

Test Plan:
- Bytes 0x05, 0x03, 0x20 (ADD) with rx_done pulses -> tx_data=0x08; tx_start pulses once 3 cycles after the 3rd rx_done; FSM returns to GET_A after tx_done.
- Bytes 0x03, 0x05, 0x22 (SUB) -> tx_data=0xFE. Then bytes 0x80, 0x02, 0x03 (SRA) -> tx_data=0xE0.
- Bytes 0x0F, 0xF0, 0xFF -> opcode 6'b111111 (invalid) -> tx_data=0xFF.
- Hold tx_done low 20 cycles and inject rx_done 0xAA during WAIT_TX -> tx_data stays held and busy=1; operands unchanged; next transaction starts fresh at GET_A. With ALU_SEQ_OVERRUN_EN, overrun=1.
- Assert reset after the 2nd byte and again in WAIT_TX -> all outputs 0 and state GET_A the same cycle (asynchronous); no tx_start emitted.
- Back-to-back: tx_done arrives, then 3 more bytes arrive on consecutive cycles -> all captured; a second result is correctly transmitted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU/sequencer definitions: opcode constants, FSM state encoding, default widths.
package alu_pkg;

  localparam int NBITS_DEF  = 8;
  localparam int COD_OP_DEF = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [2:0] {
    ST_GET_A   = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_OP  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } seq_state_e;

endpackage

// File: rtl/alu_uart_sequencer.sv
// Collects A, B and opcode bytes from the UART receiver, latches the ALU result and hands it to the
// transmitter. Define ALU_SEQ_OVERRUN_EN to add a sticky 'overrun' flag for bytes dropped while busy.
module alu_uart_sequencer
  import alu_pkg::*;
#(
  parameter int NBITS  = NBITS_DEF,
  parameter int COD_OP = COD_OP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NBITS-1:0]  rx_data,
  input  logic              rx_done,
  output logic [NBITS-1:0]  operando_A,
  output logic [NBITS-1:0]  operando_B,
  output logic [COD_OP-1:0] cod_operacion,
  input  logic [NBITS-1:0]  alu_result,
  output logic [NBITS-1:0]  tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              busy
`ifdef ALU_SEQ_OVERRUN_EN
  ,
  output logic              overrun
`endif
);

  seq_state_e        state_q, state_d;
  logic [NBITS-1:0]  a_q, a_d;
  logic [NBITS-1:0]  b_q, b_d;
  logic [COD_OP-1:0] op_q, op_d;
  logic [NBITS-1:0]  tx_q, tx_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tx_d    = tx_q;
    unique case (state_q)
      ST_GET_A: if (rx_done) begin
        a_d     = rx_data;
        state_d = ST_GET_B;
      end
      ST_GET_B: if (rx_done) begin
        b_d     = rx_data;
        state_d = ST_GET_OP;
      end
      ST_GET_OP: if (rx_done) begin
        op_d    = rx_data[COD_OP-1:0];
        state_d = ST_EXEC;
      end
      // Opcode register is already driving the ALU here, so its result is settled.
      ST_EXEC: begin
        tx_d    = alu_result;
        state_d = ST_SEND;
      end
      ST_SEND:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: if (tx_done) state_d = ST_GET_A;
      default:    state_d = ST_GET_A;
    endcase
  end

  // Outputs decode straight from the state register: glitch-free and cleared with reset.
  assign tx_start      = (state_q == ST_SEND);
  assign busy          = (state_q == ST_EXEC) || (state_q == ST_SEND) || (state_q == ST_WAIT_TX);
  assign operando_A    = a_q;
  assign operando_B    = b_q;
  assign cod_operacion = op_q;
  assign tx_data       = tx_q;

`ifdef ALU_SEQ_OVERRUN_EN
  logic ovr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              ovr_q <= 1'b0;
    else if (rx_done && busy) ovr_q <= 1'b1;
  end
  assign overrun = ovr_q;
`endif

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer with a behavioural ALU standing in for the board-level instance.
module tb_alu_uart_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic [7:0] operando_A, operando_B, tx_data, alu_result;
  logic [5:0] cod_operacion;
  logic       tx_start, tx_done = 1'b0, busy;
`ifdef ALU_SEQ_OVERRUN_EN
  logic       overrun;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_uart_sequencer #(.NBITS(8), .COD_OP(6)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .operando_A(operando_A), .operando_B(operando_B), .cod_operacion(cod_operacion),
    .alu_result(alu_result), .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .busy(busy)
`ifdef ALU_SEQ_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  // External ALU model
  always_comb begin
    case (cod_operacion)
      OP_ADD:  alu_result = operando_A + operando_B;
      OP_SUB:  alu_result = operando_A - operando_B;
      OP_AND:  alu_result = operando_A & operando_B;
      OP_OR:   alu_result = operando_A | operando_B;
      OP_XOR:  alu_result = operando_A ^ operando_B;
      OP_SRA:  alu_result = 8'($signed(operando_A) >>> operando_B);
      OP_SRL:  alu_result = operando_A >> operando_B;
      OP_NOR:  alu_result = ~(operando_A | operando_B);
      default: alu_result = 8'hFF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
  endtask

  // Runs one transaction up to WAIT_TX; returns at a negedge with the FSM in WAIT_TX.
  task automatic txn_to_wait(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] exp);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    chk({tag, " exec busy"}, busy, 1);
    chk({tag, " exec start"}, tx_start, 0);
    chk({tag, " opA"}, operando_A, a);
    chk({tag, " opB"}, operando_B, b);
    chk({tag, " cod"}, cod_operacion, op[5:0]);
    @(negedge clk);
    chk({tag, " send start"}, tx_start, 1);
    chk({tag, " tx_data"}, tx_data, exp);
    @(negedge clk);
    chk({tag, " wait start"}, tx_start, 0);
    chk({tag, " wait busy"}, busy, 1);
  endtask

  task automatic finish_tx(input string tag);
    tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
    chk({tag, " idle busy"}, busy, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin : stim
    int starts;
    #12;
    chk("rst busy", busy, 0);
    chk("rst start", tx_start, 0);
    chk("rst tx_data", tx_data, 0);
    chk("rst opA", operando_A, 0);
    chk("rst cod", cod_operacion, 0);
    @(negedge clk); reset = 1'b0;

    txn_to_wait("add", 8'h05, 8'h03, 8'h20, 8'h08);
    finish_tx("add");

    // tx_done outside WAIT_TX must be ignored
    send_byte(8'h03);
    @(negedge clk); tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
    chk("ignored tx_done busy", busy, 0);
    send_byte(8'h05);
    send_byte(8'h22);
    @(negedge clk);
    chk("sub tx_data", tx_data, 8'hFE);
    chk("sub start", tx_start, 1);
    @(negedge clk);
    finish_tx("sub");

    txn_to_wait("sra", 8'h80, 8'h02, 8'h03, 8'hE0);
    finish_tx("sra");

    txn_to_wait("inv", 8'h0F, 8'hF0, 8'hFF, 8'hFF);
    finish_tx("inv");

    // Stall in WAIT_TX with a stray byte arriving
    txn_to_wait("ovr", 8'h07, 8'h02, 8'h20, 8'h09);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin rx_data = 8'hAA; rx_done = 1'b1; end
      @(negedge clk); rx_done = 1'b0;
    end
    chk("ovr held tx_data", tx_data, 8'h09);
    chk("ovr busy", busy, 1);
    chk("ovr opA", operando_A, 8'h07);
    chk("ovr opB", operando_B, 8'h02);
    chk("ovr cod", cod_operacion, 6'h20);
    chk("ovr start", tx_start, 0);
`ifdef ALU_SEQ_OVERRUN_EN
    chk("overrun flag", overrun, 1);
`endif
    finish_tx("ovr");
    txn_to_wait("fresh", 8'h0C, 8'h0A, 8'h25, 8'h0E);
    finish_tx("fresh");

    // Reset after the second byte
    send_byte(8'h33);
    send_byte(8'h44);
    reset = 1'b1; #1;
    chk("rst1 opA", operando_A, 0);
    chk("rst1 opB", operando_B, 0);
    chk("rst1 busy", busy, 0);
    @(negedge clk); reset = 1'b0;

    // Reset while waiting for the transmitter
    txn_to_wait("pre", 8'h01, 8'h01, 8'h20, 8'h02);
    reset = 1'b1; #1;
    chk("rst2 tx_data", tx_data, 0);
    chk("rst2 busy", busy, 0);
    chk("rst2 start", tx_start, 0);
    chk("rst2 cod", cod_operacion, 0);
`ifdef ALU_SEQ_OVERRUN_EN
    chk("rst2 overrun", overrun, 0);
`endif
    @(negedge clk); reset = 1'b0;
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    chk("rst2 no start", starts, 0);

    // Back-to-back: tx_done then three bytes on consecutive cycles
    txn_to_wait("b2b1", 8'hF0, 8'h3C, 8'h24, 8'h30);
    tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0; rx_done = 1'b1; rx_data = 8'h0F;
    @(negedge clk); rx_data = 8'h30;
    @(negedge clk); rx_data = 8'hE7;
    @(negedge clk); rx_done = 1'b0;
    chk("b2b2 opA", operando_A, 8'h0F);
    chk("b2b2 opB", operando_B, 8'h30);
    chk("b2b2 cod", cod_operacion, 6'h27);
    @(negedge clk);
    chk("b2b2 start", tx_start, 1);
    chk("b2b2 tx_data", tx_data, 8'hC0);
    @(negedge clk);
    chk("b2b2 start drop", tx_start, 0);
    finish_tx("b2b2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
